// File: rtl/mult_div_unit.sv
// Sequential signed 32-bit multiply/divide unit for the multicycle MIPS datapath.
// MULT uses radix-2 Booth; DIV uses restoring division on magnitudes. Both take 32 steps.
module mult_div_unit (
    input  logic        clock,
    input  logic        reset,
    input  logic        start,
    input  logic        MDcontrol,
    input  logic [31:0] A,
    input  logic [31:0] B,
    output logic [31:0] HI,
    output logic [31:0] LO,
    output logic        busy,
    output logic        done,
    output logic        Div0
);

    localparam int unsigned W     = 32;
    localparam int unsigned CNT_W = 6;
    localparam logic [CNT_W-1:0] LAST_STEP = CNT_W'(W - 1);

    typedef enum logic {IDLE, RUN} state_t;

    state_t           state, state_n;
    logic [CNT_W-1:0] cnt, cnt_n;
    logic [W:0]       acc, acc_n;
    logic [W-1:0]     q, q_n;
    logic             q1, q1_n;
    logic [W:0]       m, m_n;
    logic             op, op_n;
    logic             neg_q, neg_q_n;
    logic             neg_r, neg_r_n;
    logic [W-1:0]     hi_n, lo_n;
    logic             busy_n, done_n, div0_n;

    // Booth step: add/subtract multiplicand then arithmetic shift of {acc, q, q1}
    logic [W:0]       sum;
    logic [W:0]       acc_b;
    logic [W-1:0]     q_b;

    // Restoring divide step: shift in next dividend bit, trial subtract
    logic [W:0]       r_sh;
    logic [W+1:0]     diff;
    logic             ge;
    logic [W:0]       acc_d;
    logic [W-1:0]     q_d;

    logic [W-1:0]     a_mag, b_mag;
    logic             div_by_zero;

    always_comb begin
        case ({q[0], q1})
            2'b01:   sum = acc + m;
            2'b10:   sum = acc - m;
            default: sum = acc;
        endcase
        acc_b = {sum[W], sum[W:1]};
        q_b   = {sum[0], q[W-1:1]};

        r_sh  = {acc[W-1:0], q[W-1]};
        diff  = {1'b0, r_sh} - {1'b0, m};
        ge    = ~diff[W+1];
        acc_d = ge ? diff[W:0] : r_sh;
        q_d   = {q[W-2:0], ge};

        a_mag = A[W-1] ? W'(-A) : A;
        b_mag = B[W-1] ? W'(-B) : B;
        div_by_zero = MDcontrol && (B == '0);
    end

    // State and datapath registers
    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            state <= IDLE;
            cnt   <= '0;
            acc   <= '0;
            q     <= '0;
            q1    <= 1'b0;
            m     <= '0;
            op    <= 1'b0;
            neg_q <= 1'b0;
            neg_r <= 1'b0;
            HI    <= '0;
            LO    <= '0;
            busy  <= 1'b0;
            done  <= 1'b0;
            Div0  <= 1'b0;
        end else begin
            state <= state_n;
            cnt   <= cnt_n;
            acc   <= acc_n;
            q     <= q_n;
            q1    <= q1_n;
            m     <= m_n;
            op    <= op_n;
            neg_q <= neg_q_n;
            neg_r <= neg_r_n;
            HI    <= hi_n;
            LO    <= lo_n;
            busy  <= busy_n;
            done  <= done_n;
            Div0  <= div0_n;
        end
    end

    // Next-state logic
    always_comb begin
        state_n = state;
        case (state)
            IDLE:    if (start && !div_by_zero) state_n = RUN;
            RUN:     if (cnt == LAST_STEP) state_n = IDLE;
            default: state_n = IDLE;
        endcase
    end

    // Datapath and registered-output next values
    always_comb begin
        cnt_n   = cnt;
        acc_n   = acc;
        q_n     = q;
        q1_n    = q1;
        m_n     = m;
        op_n    = op;
        neg_q_n = neg_q;
        neg_r_n = neg_r;
        hi_n    = HI;
        lo_n    = LO;
        busy_n  = busy;
        done_n  = 1'b0;
        div0_n  = 1'b0;

        case (state)
            IDLE: begin
                if (start) begin
                    if (div_by_zero) begin
                        div0_n = 1'b1;
                    end else begin
                        op_n   = MDcontrol;
                        cnt_n  = '0;
                        busy_n = 1'b1;
                        acc_n  = '0;
                        q1_n   = 1'b0;
                        if (MDcontrol) begin
                            q_n     = a_mag;
                            m_n     = {1'b0, b_mag};
                            neg_q_n = A[W-1] ^ B[W-1];
                            neg_r_n = A[W-1];
                        end else begin
                            q_n     = B;
                            m_n     = {A[W-1], A};
                            neg_q_n = 1'b0;
                            neg_r_n = 1'b0;
                        end
                    end
                end
            end
            RUN: begin
                cnt_n = cnt + CNT_W'(1);
                if (op) begin
                    acc_n = acc_d;
                    q_n   = q_d;
                end else begin
                    acc_n = acc_b;
                    q_n   = q_b;
                    q1_n  = q[0];
                end
                if (cnt == LAST_STEP) begin
                    cnt_n  = '0;
                    busy_n = 1'b0;
                    done_n = 1'b1;
                    if (op) begin
                        hi_n = neg_r ? W'(-acc_d[W-1:0]) : acc_d[W-1:0];
                        lo_n = neg_q ? W'(-q_d) : q_d;
                    end else begin
                        hi_n = acc_b[W-1:0];
                        lo_n = q_b;
                    end
                end
            end
            default: ;
        endcase
    end

endmodule
